// File: rtl/sim_mngr_if.sv
// Bundle of control, parameter, generator-handshake and report signals
// between the simulation manager and its environment.
interface sim_mngr_if;
  // run request and sampled run parameters
  logic        go;
  logic [8:0]  mu;
  logic [8:0]  alpha;
  logic [7:0]  beta;
  logic [15:0] t_max;
  logic [7:0]  max_events;
  // event generator handshake
  logic [8:0]  ev_s;
  logic        ev_s_done;
  logic        ev_done;
  logic        ev_start;
  logic [8:0]  lambda;
  logic [8:0]  next_lambda;
  logic [7:0]  D1;
  logic [7:0]  D2;
  // accepted-event report and run status
  logic        event_valid;
  logic [15:0] event_time;
  logic [7:0]  event_count;
  logic        busy;
  logic        finished;
  logic        timeout_err;

  modport slave (
    input  go, mu, alpha, beta, t_max, max_events, ev_s, ev_s_done, ev_done,
    output ev_start, lambda, next_lambda, D1, D2,
           event_valid, event_time, event_count, busy, finished, timeout_err
  );

  modport master (
    output go, mu, alpha, beta, t_max, max_events, ev_s, ev_s_done, ev_done,
    input  ev_start, lambda, next_lambda, D1, D2,
           event_valid, event_time, event_count, busy, finished, timeout_err
  );
endinterface

// File: rtl/sim_mngr.sv
// Sequencer for a self-exciting (Hawkes-style) event simulation: draws
// random bytes for an external event generator, decays the intensity over
// each candidate gap, and commits accepted events until the time horizon,
// the event limit or a generator timeout ends the run.
module sim_mngr #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 64
) (
  input logic       clk,
  input logic       rst_n,
  sim_mngr_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAW   = 3'd1,
    WAIT_S = 3'd2,
    DECAY  = 3'd3,
    TEST   = 3'd4,
    COMMIT = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  mu_q, mu_d, alpha_q, alpha_d;
  logic [7:0]  beta_q, beta_d, max_ev_q, max_ev_d;
  logic [15:0] t_max_q, t_max_d, t_q, t_d;
  logic [16:0] t_new_q, t_new_d;
  logic [8:0]  s_q, s_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        accept_q, accept_d;
  logic [8:0]  lambda_q, lambda_d, next_lambda_q, next_lambda_d;
  logic [7:0]  d1_q, d1_d, d2_q, d2_d;
  logic        ev_start_q, ev_start_d, ev_valid_q, ev_valid_d;
  logic [15:0] ev_time_q, ev_time_d;
  logic [7:0]  ev_count_q, ev_count_d;
  logic        busy_q, busy_d, finished_q, finished_d, timeout_q, timeout_d;

  // datapath helpers
  logic [15:0] lfsr_step_s;
  logic [16:0] bs_prod_s;
  logic [8:0]  bs_shift_s, f_s, excess_s;
  logic [17:0] scaled_s;
  logic [9:0]  sat_sum_s;
  logic [7:0]  count_inc_s;

  // Galois LFSR step, right-shifting form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  assign lfsr_step_s = lfsr_next(lfsr_q);
  assign bs_prod_s   = 17'(beta_q) * 17'(s_q);
  assign bs_shift_s  = 9'(bs_prod_s >> 8);
  assign f_s         = (bs_shift_s >= 9'd256) ? 9'd0 : (9'd256 - bs_shift_s);
  assign excess_s    = lambda_q - mu_q;
  assign scaled_s    = 18'(excess_s) * 18'(f_s);
  assign sat_sum_s   = {1'b0, next_lambda_q} + {1'b0, alpha_q};
  assign count_inc_s = ev_count_q + 8'd1;

  // next-state and register-update logic of the run sequencer
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    mu_d          = mu_q;
    alpha_d       = alpha_q;
    beta_d        = beta_q;
    max_ev_d      = max_ev_q;
    t_max_d       = t_max_q;
    t_d           = t_q;
    t_new_d       = t_new_q;
    s_d           = s_q;
    wait_cnt_d    = wait_cnt_q;
    accept_d      = accept_q;
    lambda_d      = lambda_q;
    next_lambda_d = next_lambda_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    ev_start_d    = 1'b0;
    ev_valid_d    = 1'b0;
    ev_time_d     = ev_time_q;
    ev_count_d    = ev_count_q;
    timeout_d     = timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          mu_d       = bus.mu;
          alpha_d    = bus.alpha;
          beta_d     = bus.beta;
          t_max_d    = bus.t_max;
          max_ev_d   = bus.max_events;
          lambda_d   = bus.mu;
          t_d        = 16'd0;
          ev_count_d = 8'd0;
          timeout_d  = 1'b0;
          lfsr_d     = SEED;
          state_d    = DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        lfsr_d     = lfsr_step_s;
        d1_d       = (lfsr_step_s[15:8] == 8'd0) ? 8'h01 : lfsr_step_s[15:8];
        d2_d       = lfsr_step_s[7:0];
        ev_start_d = 1'b1;
        wait_cnt_d = 16'd0;
        state_d    = WAIT_S;
      end
      WAIT_S: begin
        // the first cycle is skipped so a stale ev_s_done cannot be taken
        if ((wait_cnt_q != 16'd0) && bus.ev_s_done) begin
          s_d     = bus.ev_s;
          state_d = DECAY;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      DECAY: begin
        next_lambda_d = 9'(mu_q + 9'(scaled_s >> 8));
        t_new_d       = {1'b0, t_q} + 17'(s_q);
        state_d       = TEST;
      end
      TEST: begin
        accept_d = bus.ev_done;
        if (t_new_q[16] || (t_new_q > {1'b0, t_max_q})) begin
          state_d = DONE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        t_d = t_new_q[15:0];
        if (accept_q) begin
          lambda_d   = sat_sum_s[9] ? 9'h1FF : sat_sum_s[8:0];
          ev_valid_d = 1'b1;
          ev_time_d  = t_new_q[15:0];
          ev_count_d = count_inc_s;
        end else begin
          lambda_d = next_lambda_q;
        end
        // a zero limit means the run is bounded only by time
        if (accept_q && (max_ev_q != 8'd0) && (count_inc_s == max_ev_q)) begin
          state_d = DONE;
        end else begin
          state_d = DRAW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // status flags are registered copies of the state being entered
    busy_d     = (state_d != IDLE);
    finished_d = (state_d == DONE);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      mu_q          <= 9'd0;
      alpha_q       <= 9'd0;
      beta_q        <= 8'd0;
      max_ev_q      <= 8'd0;
      t_max_q       <= 16'd0;
      t_q           <= 16'd0;
      t_new_q       <= 17'd0;
      s_q           <= 9'd0;
      wait_cnt_q    <= 16'd0;
      accept_q      <= 1'b0;
      lambda_q      <= 9'd0;
      next_lambda_q <= 9'd0;
      d1_q          <= 8'd0;
      d2_q          <= 8'd0;
      ev_start_q    <= 1'b0;
      ev_valid_q    <= 1'b0;
      ev_time_q     <= 16'd0;
      ev_count_q    <= 8'd0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      mu_q          <= mu_d;
      alpha_q       <= alpha_d;
      beta_q        <= beta_d;
      max_ev_q      <= max_ev_d;
      t_max_q       <= t_max_d;
      t_q           <= t_d;
      t_new_q       <= t_new_d;
      s_q           <= s_d;
      wait_cnt_q    <= wait_cnt_d;
      accept_q      <= accept_d;
      lambda_q      <= lambda_d;
      next_lambda_q <= next_lambda_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      ev_start_q    <= ev_start_d;
      ev_valid_q    <= ev_valid_d;
      ev_time_q     <= ev_time_d;
      ev_count_q    <= ev_count_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.ev_start    = ev_start_q;
  assign bus.lambda      = lambda_q;
  assign bus.next_lambda = next_lambda_q;
  assign bus.D1          = d1_q;
  assign bus.D2          = d2_q;
  assign bus.event_valid = ev_valid_q;
  assign bus.event_time  = ev_time_q;
  assign bus.event_count = ev_count_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = finished_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: doc/sim_mngr.md
SIM_MNGR -- requirements
Module: sim_mngr

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR value loaded at reset and on each go.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT_S cycles before abort.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port go, input, 1 bit: one-cycle run request, honoured only in IDLE.
REQ-006 SHALL have inputs mu [8:0], alpha [8:0] and beta [7:0]: base intensity and jump (Q1.8), and decay rate (Q0.8); all sampled on go.
REQ-007 SHALL have inputs t_max [15:0] (Q8.8 time horizon) and max_events [7:0] (event limit); both sampled on go.
REQ-008 SHALL have inputs ev_s [8:0] (candidate gap, Q1.8), ev_s_done (gap valid) and ev_done (accept flag), all from the event generator.
REQ-009 SHALL have outputs ev_start (1 bit), lambda [8:0], next_lambda [8:0], D1 [7:0] and D2 [7:0]: drive lines to the event generator.
REQ-010 SHALL have outputs event_valid (1 bit), event_time [15:0] and event_count [7:0]: accepted-event report.
REQ-011 SHALL have outputs busy, finished and timeout_err, each 1 bit: run status.

Function
REQ-012 SHALL implement FSM states IDLE, DRAW, WAIT_S, DECAY, TEST, COMMIT, DONE.
REQ-013 IDLE with go=1 SHALL latch the parameters and set lambda=mu, t=0, event_count=0, timeout_err=0 and LFSR=SEED, then go to DRAW; busy=1 in every state except IDLE.
REQ-014 DRAW SHALL advance the 16-bit Galois LFSR (taps 16,14,13,11), set D1=lfsr[15:8] (forced to 8'h01 when zero) and D2=lfsr[7:0], and pulse ev_start for exactly one cycle.
REQ-015 D1, D2 and lambda SHALL stay stable from DRAW until COMMIT completes.
REQ-016 WAIT_S SHALL ignore ev_s_done in its first cycle, capture ev_s into s_reg on the first later cycle with ev_s_done=1, and go to DECAY.
REQ-017 If TIMEOUT cycles pass in WAIT_S without a capture, the block SHALL set timeout_err=1 and go to DONE.
REQ-018 DECAY SHALL compute f = 256 - min(256, (beta*s_reg)>>8) and next_lambda = mu + (((lambda-mu)*f)>>8), with lambda >= mu guaranteed, 18-bit intermediates and the result truncated to 9 bits.
REQ-019 DECAY SHALL compute t_new = t + s_reg at 17 bits.
REQ-020 TEST SHALL sample ev_done one cycle after next_lambda is updated.
REQ-021 If t_new > t_max or t_new[16]=1, TEST SHALL discard the candidate and go to DONE.
REQ-022 Otherwise TEST SHALL go to COMMIT.
REQ-023 COMMIT SHALL set t=t_new.
REQ-024 On accept, COMMIT SHALL set lambda=min(511, next_lambda+alpha), pulse event_valid for one cycle with event_time=t_new, and increment event_count.
REQ-025 On reject, COMMIT SHALL set lambda=next_lambda.
REQ-026 COMMIT SHALL go to DONE when event_count reaches max_events; otherwise it SHALL go to DRAW.
REQ-027 max_events=0 SHALL mean unlimited events.
REQ-028 DONE SHALL pulse finished for one cycle and return to IDLE; results and timeout_err hold until the next go.
REQ-029 go outside IDLE SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, LFSR=SEED, and zero on every output and internal register, including lambda, next_lambda, D1, D2, event_time, event_count, ev_start, event_valid, busy, finished and timeout_err.
REQ-031 Reset asserted mid-run SHALL abort the run with no event_valid or finished pulse.
REQ-032 After rst_n rises, a go pulse SHALL be required to start a new run.

Verification
REQ-033 Reset: assert rst_n=0 mid-WAIT_S -> all outputs 0 in the same cycle; no finished pulse follows.
REQ-034 No decay: mu=0x100, alpha=0x040, beta=0, generator model returns s=0x020 three cycles after ev_start with accept=1 -> events at times 0x0020 then 0x0040, lambda 0x140 then 0x180.
REQ-035 Decay: mu=0x100, lambda excess 0x040, beta=0x80, s=0x100, accept=0 -> next_lambda=0x120, event_count unchanged.
REQ-036 Saturation: mu=0x100, alpha=0x1FF, accept=1 -> lambda=0x1FF.
REQ-037 Horizon: t_max=0x0030, s=0x020, always accept -> one event at 0x0020, then finished with event_count=1.
REQ-038 Timeout: ev_s_done held low -> timeout_err=1 and a finished pulse exactly TIMEOUT cycles after entering WAIT_S, then busy=0.
